// File: rtl/parity_rr_scheduler.sv
// rtl/parity_rr_scheduler.sv - round-robin shared parity unit with accept/compute/respond FSM
module parity_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_even_parity,
  output logic                      rsp_odd_parity,
  output logic                      busy,
  output logic [CNT_W-1:0]          done_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [ID_W-1:0]     r_rsp_id;
  logic                r_even;
  logic                r_odd;
  logic [CNT_W-1:0]    r_done;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [ID_W:0]        w_shift;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_found;
  logic [ID_W-1:0]      w_winner;
  logic [DATA_W-1:0]    w_sel_data;
  logic                 w_accept;

  // Rotate requests so bit 0 is the requester just after the last winner.
  assign w_dbl   = {req_valid, req_valid};
  assign w_shift = {1'b0, r_ptr} + {{ID_W{1'b0}}, 1'b1};
  assign w_rot   = NUM_REQ'(w_dbl >> w_shift);

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found  = 1'b1;
        w_winner = ID_W'((int'(r_ptr) + 1 + k) % NUM_REQ);
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found;

  always_comb begin
    w_sel_data = '0;
    req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_sel_data   = req_data[i*DATA_W +: DATA_W];
        req_ready[i] = w_accept && !rst;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_next = S_COMPUTE;
      S_COMPUTE: w_next = S_RESPOND;
      S_RESPOND: if (rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= ID_W'(NUM_REQ - 1);
      r_rsp_id <= '0;
      r_even   <= 1'b0;
      r_odd    <= 1'b0;
      r_done   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_ptr <= w_winner;
      if (r_state == S_COMPUTE) begin
        r_rsp_id <= r_id;
        r_even   <= ^r_data;
        r_odd    <= ~^r_data;
      end
      if (r_state == S_RESPOND && rsp_ready) r_done <= r_done + 1'b1;
    end
  end

  // Latched request payload is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data <= w_sel_data;
      r_id   <= w_winner;
    end
  end

  assign rsp_valid       = (r_state == S_RESPOND);
  assign busy            = (r_state != S_IDLE);
  assign rsp_id          = r_rsp_id;
  assign rsp_even_parity = r_even;
  assign rsp_odd_parity  = r_odd;
  assign done_count      = r_done;

endmodule

// File: tb/tb_parity_rr_scheduler.sv
// tb/tb_parity_rr_scheduler.sv - table-driven bench for parity_rr_scheduler
module tb_parity_rr_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 8;
  localparam int ID_W     = 2;
  localparam int TB_CNT_W = 6;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_even_parity;
  logic                      rsp_odd_parity;
  logic                      busy;
  logic [TB_CNT_W-1:0]       done_count;

  parity_rr_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W), .CNT_W(TB_CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_even_parity(rsp_even_parity),
    .rsp_odd_parity(rsp_odd_parity), .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_before;
    logic [3:0]  v;
    logic [31:0] d;
    int          id;
    logic        ev;
    logic        od;
  } vec_t;

  vec_t                vecs[13];
  int                  n_vec = 0;
  int                  n_err = 0;
  logic [TB_CNT_W-1:0] done_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    done_model = '0;
  endtask

  // Entered and left at a negedge with the DUT in IDLE; rsp_ready is held high throughout.
  task automatic do_txn(input logic [3:0] v, input logic [31:0] d, input int id,
                        input logic ev, input logic od);
    req_valid = v; req_data = d; rsp_ready = 1'b1;
    #1;
    check("grant", 32'(req_ready), 32'(1) << id);
    @(posedge clk); @(negedge clk);
    check("compute_ready", 32'(req_ready), 32'd0);
    check("compute_busy", 32'(busy), 32'd1);
    check("compute_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_even", 32'(rsp_even_parity), 32'(ev));
    check("rsp_odd", 32'(rsp_odd_parity), 32'(od));
    @(posedge clk); @(negedge clk);
    done_model = done_model + 1'b1;
    check("done_count", 32'(done_count), 32'(done_model));
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'b0001, 32'h000000A5, 0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 4'b1111, 32'h01030700, 0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 4'b1111, 32'h01030700, 1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'b1111, 32'h01030700, 2, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 4'b1111, 32'h01030700, 3, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 32'h01030700, 0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 4'b0100, 32'h3380007F, 2, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'b0100, 32'h3380007F, 2, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'b0100, 32'h3380007F, 2, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'b0110, 32'h3380007F, 1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 4'b0110, 32'h3380007F, 2, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'b1001, 32'h3380007F, 3, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 4'b1001, 32'h3380007F, 0, 1'b1, 1'b0};

    rst = 1'b1; req_valid = 4'b1111; req_data = '0; rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done_count), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_even", 32'(rsp_even_parity), 32'd0);
    check("reset_odd", 32'(rsp_odd_parity), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst_before) do_reset();
      do_txn(vecs[i].v, vecs[i].d, vecs[i].id, vecs[i].ev, vecs[i].od);
    end
    req_valid = '0;

    // Backpressure: five stalled cycles in RESPOND with all requesters pending.
    do_reset();
    req_valid = 4'b0010; req_data = 32'h0000FF00; rsp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 4'b1111;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_even", 32'(rsp_even_parity), 32'd0);
      check("bp_odd", 32'(rsp_odd_parity), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = '0;
    @(posedge clk); @(negedge clk);
    done_model = done_model + 1'b1;
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_done", 32'(done_count), 32'(done_model));

    // Reset during COMPUTE aborts the transaction and restores the pointer.
    do_reset();
    do_txn(4'b0100, 32'h3380007F, 2, 1'b1, 1'b0);
    req_valid = 4'b0010;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; req_valid = 4'b1001;
    @(posedge clk); @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_done", 32'(done_count), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    done_model = '0;
    do_txn(4'b1001, 32'h3380007F, 0, 1'b1, 1'b0);

    // Completed-transaction counter wraps to zero.
    do_reset();
    for (int n = 0; n < (1 << TB_CNT_W) - 1; n++)
      do_txn(4'b0001, 32'h000000A5, 0, 1'b0, 1'b1);
    check("done_all_ones", 32'(done_count), 32'((1 << TB_CNT_W) - 1));
    do_txn(4'b0001, 32'h000000A5, 0, 1'b0, 1'b1);
    check("done_wrap", 32'(done_count), 32'd0);
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
